fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the combinational instruction memory.
- Owns the program counter and drives it to the memory's pc input. Captures the returned instruction into an instruction register (IR) and presents it to decode over a valid/ready handshake.
- Handles start, stall (backpressure), jump/flush and halt.

Parameters:
- INSTRUCTION_WIDTH, 40, width of the instruction word, matching the memory output.
- PC_WIDTH, 5, program-counter width; address space is 2**PC_WIDTH words.
- OPCODE_WIDTH, 8, number of instruction MSBs treated as the opcode.
- HALT_OPCODE, 8'hFF, opcode value that stops fetching.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begins fetching from address 0 while IDLE.
- pc  output  PC_WIDTH  address driven to instruction memory (registered).
- mem_instr  input  INSTRUCTION_WIDTH  memory data for the current pc, valid in the same cycle.
- ir_data  output  INSTRUCTION_WIDTH  captured instruction for decode.
- ir_pc  output  PC_WIDTH  address the ir_data was fetched from.
- ir_valid  output  1  ir_data/ir_pc hold an unconsumed instruction.
- ir_ready  input  1  decode accepts the IR this cycle.
- jmp_en  input  1  redirect request from downstream (taken branch/jump).
- jmp_addr  input  PC_WIDTH  redirect target.
- halted  output  1  high while in HALT.

Behaviour:
- Reset (async, any time, including mid-transfer) forces the following; no transfer completes in a reset cycle:
  - pc=0, ir_data=0, ir_pc=0, ir_valid=0, halted=0.
  - state=IDLE.
- States: IDLE, FETCH, HALT (2-bit encoding).
- IDLE:
  - pc is held at 0 and ir_valid=0.
  - start=1 moves to FETCH next cycle.
  - jmp_en=1 in IDLE also moves to FETCH with pc<=jmp_addr; jmp_en has priority over start.
- Advance condition, "adv" = (state==FETCH) && (!ir_valid || ir_ready).
- FETCH with adv and no jump:
  - ir_data<=mem_instr, ir_pc<=pc, ir_valid<=1.
  - pc<=pc+1, truncated to PC_WIDTH.
  - Result: one instruction per cycle at full throughput, with one cycle of latency from pc to ir_valid.
- FETCH with !adv (ir_valid && !ir_ready):
  - Stall; pc, ir_data, ir_pc and ir_valid all hold.
  - No instruction is lost or duplicated.
- Consumption without refill: if ir_valid && ir_ready && !adv (HALT state), ir_valid<=0.
- jmp_en=1 (highest priority after reset):
  - pc<=jmp_addr and ir_valid<=0, which flushes the IR; nothing is captured that cycle. Any IR accepted by ir_ready that cycle counts as consumed.
  - From FETCH the state stays FETCH; from HALT it goes to FETCH and halted<=0.
- Halt:
  - When adv captures an instruction with mem_instr[MSB -: OPCODE_WIDTH]==HALT_OPCODE, that instruction is still presented in the IR.
  - pc is not incremented; state<=HALT and halted<=1 next cycle.
  - In HALT, pc is frozen and no capture occurs; the pending IR drains normally via ir_ready.
  - start is ignored; only jmp_en or rst leave HALT.
- End of address space: behaviour at pc==2**PC_WIDTH-1 is given under Optional Feature.
- Simultaneous start and jmp_en in IDLE: jmp wins.
- jmp_en together with a halt opcode on mem_instr: jmp wins and no halt occurs.

Optional Feature:
- Macro: FETCH_WRAP_EN.
- Defined: on capture at pc==2**PC_WIDTH-1, pc wraps to 0 and fetching continues in FETCH.
- Undefined: that capture is completed, pc stays at 2**PC_WIDTH-1, and state<=HALT with halted=1, exactly as for a halt opcode.

Decomposition:
- Shared package fetch_pkg holds:
  - the state typedef enum {IDLE, FETCH, HALT};
  - OPCODE_WIDTH and HALT_OPCODE defaults;
  - a function is_halt(instr).
- No sub-module; the PC register, IR and FSM sit in a single module.
- The memory is instantiated alongside it at top level, not inside it.

Test Plan:
- Reset then start pulse, ir_ready=1, memory words 0..3 = 40'h01..04 (word 4 = 40'hFF00000000). Required: ir_valid rises one cycle after start+1; ir_pc 0,1,2,3,4 on consecutive cycles; halted=1 after word 4; pc held at 4.
- Backpressure: hold ir_ready=0 for 3 cycles while ir_pc=2. Required: ir_data, ir_pc and pc are frozen; on release, ir_pc sequence 2,3 with no skip or duplicate.
- Jump: jmp_en=1, jmp_addr=5'd20 while FETCH at pc=6. Required: next cycle ir_valid=0 and pc=20; the cycle after, ir_pc=20.
- HALT recovery: in HALT, pulse start (no effect), then jmp_en with jmp_addr=3. Required: halted=0 and fetching resumes at ir_pc=3.
- End of space with no halt opcodes and ir_ready=1:
  - without FETCH_WRAP_EN: last ir_pc=31, then halted=1;
  - with FETCH_WRAP_EN: ir_pc 31 is followed by 0.
- Async reset asserted mid-stall with ir_valid=1. Required: all outputs return to 0 immediately, without waiting for a clock edge; state=IDLE.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants.
// Opcode helpers used by fetch and decode.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam int INSTR_WIDTH = 40;
  localparam int OPCODE_WIDTH = 8;
  localparam logic [OPCODE_WIDTH-1:0] HALT_OPCODE = 8'hFF;

  function automatic logic is_halt(
    input logic [INSTR_WIDTH-1:0] instr
  );
    return instr[INSTR_WIDTH-1 -: OPCODE_WIDTH] == HALT_OPCODE;
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, IR and start/stall/jump/halt control.
// FETCH_WRAP_EN: pc wraps at end of space instead of halting.
import fetch_pkg::*;

module fetch_unit #(
  parameter int INSTRUCTION_WIDTH = fetch_pkg::INSTR_WIDTH,
  parameter int PC_WIDTH = 5,
  parameter int OPCODE_WIDTH = fetch_pkg::OPCODE_WIDTH,
  parameter logic [OPCODE_WIDTH-1:0] HALT_OPCODE =
    fetch_pkg::HALT_OPCODE
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic [PC_WIDTH-1:0]          pc,
  input  logic [INSTRUCTION_WIDTH-1:0] mem_instr,
  output logic [INSTRUCTION_WIDTH-1:0] ir_data,
  output logic [PC_WIDTH-1:0]          ir_pc,
  output logic                         ir_valid,
  input  logic                         ir_ready,
  input  logic                         jmp_en,
  input  logic [PC_WIDTH-1:0]          jmp_addr,
  output logic                         halted
);

  localparam logic [PC_WIDTH-1:0] PC_LAST = '1;

  state_t state, state_nx;
  logic   adv;
  logic   op_halt;
  logic   stop;

  assign adv = (state == FETCH) && (!ir_valid || ir_ready);
  assign op_halt =
    mem_instr[INSTRUCTION_WIDTH-1 -: OPCODE_WIDTH] == HALT_OPCODE;

`ifdef FETCH_WRAP_EN
  assign stop = op_halt;
`else
  // Last word of the address space ends the program like a halt.
  assign stop = op_halt || (pc == PC_LAST);
`endif

  assign halted = (state == HALT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (jmp_en || start) state_nx = FETCH;
      end
      FETCH: begin
        if (!jmp_en && adv && stop) state_nx = HALT;
      end
      HALT: begin
        if (jmp_en) state_nx = FETCH;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= '0;
      ir_data  <= '0;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
    end else if (jmp_en) begin
      pc       <= jmp_addr;
      ir_valid <= 1'b0;
    end else if (adv) begin
      ir_data  <= mem_instr;
      ir_pc    <= pc;
      ir_valid <= 1'b1;
      if (!stop) pc <= pc + 1'b1;
    end else if (ir_valid && ir_ready) begin
      ir_valid <= 1'b0;
    end
  end

endmodule
